// File: rtl/timer_step_ctrl_if.sv
// Shared 8-bit incrementor bus: controller drives the operand, incrementor returns operand+1.
interface timer_step_ctrl_if;
    localparam int unsigned IW = 8;

    logic [IW-1:0] inc_a;
    logic [IW-1:0] inc_y;

    modport master (output inc_a, input inc_y);
    modport slave  (input inc_a, output inc_y);
endinterface

// File: rtl/timer_step_ctrl.sv
// Two-mode timer sequencer: keeps the mm:ss count and time-shares one external
// incrementor for counting up (stopwatch) and down (countdown, x-1 = ~(~x+1)).
module timer_step_ctrl #(
    parameter int unsigned SEC_MAX = 59,
    parameter int unsigned MIN_MAX = 99
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              start_stop,
    input  logic              clear,
    input  logic              mode,
    input  logic [6:0]        preset_min,
    input  logic [5:0]        preset_sec,
    timer_step_ctrl_if.master inc_bus,
    output logic [6:0]        min_o,
    output logic [5:0]        sec_o,
    output logic              running,
    output logic              busy,
    output logic              done
);
    localparam int unsigned MW = 7;
    localparam int unsigned SW = 6;
    localparam int unsigned IW = 8;
    localparam logic [SW-1:0] SEC_LAST = SW'(SEC_MAX);
    localparam logic [MW-1:0] MIN_LAST = MW'(MIN_MAX);

    typedef enum logic [2:0] {
        ST_IDLE, ST_RUN, ST_SEC_UPD, ST_MIN_UPD, ST_PAUSE, ST_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [MW-1:0] min_q, min_d;
    logic [SW-1:0] sec_q, sec_d;
    logic          mode_q, mode_d;
    logic          tick_pend_q, tick_pend_d;
    logic          stop_pend_q, stop_pend_d;
    logic [IW-1:0] inc_a_q, inc_a_d;
    logic          running_q, running_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          stop_req;
    logic [SW-1:0] sec_dec;
    logic          unused_inc_msb;

    // Seconds field after a decrement: ~(~sec + 1).
    assign sec_dec        = ~inc_bus.inc_y[SW-1:0];
    assign unused_inc_msb = inc_bus.inc_y[IW-1];

    // Next state, count update, pending flags and registered output values.
    always_comb begin
        state_d     = state_q;
        min_d       = min_q;
        sec_d       = sec_q;
        mode_d      = mode_q;
        tick_pend_d = tick_pend_q;
        stop_pend_d = stop_pend_q;
        inc_a_d     = '0;
        stop_req    = stop_pend_q | start_stop;

        case (state_q)
            ST_IDLE: begin
                if (start_stop) begin
                    mode_d = mode;
                    if (!mode) begin
                        min_d   = '0;
                        sec_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        min_d   = preset_min;
                        sec_d   = preset_sec;
                        state_d = (preset_min == '0 && preset_sec == '0) ? ST_DONE : ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (tick || tick_pend_q) begin
                    state_d     = ST_SEC_UPD;
                    tick_pend_d = 1'b0;
                    if (start_stop) stop_pend_d = 1'b1;
                end else if (start_stop) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_SEC_UPD: begin
                if (tick) tick_pend_d = 1'b1;
                if (!mode_q) begin
                    if (sec_q != SEC_LAST) begin
                        sec_d   = inc_bus.inc_y[SW-1:0];
                        state_d = ST_RUN;
                    end else if (min_q != MIN_LAST) begin
                        sec_d   = '0;
                        state_d = ST_MIN_UPD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    if (sec_q != '0) begin
                        sec_d   = sec_dec;
                        state_d = (min_q == '0 && sec_dec == '0) ? ST_DONE : ST_RUN;
                    end else begin
                        sec_d   = SEC_LAST;
                        state_d = ST_MIN_UPD;
                    end
                end
            end
            ST_MIN_UPD: begin
                if (tick) tick_pend_d = 1'b1;
                min_d   = mode_q ? ~inc_bus.inc_y[MW-1:0] : inc_bus.inc_y[MW-1:0];
                state_d = ST_RUN;
            end
            ST_PAUSE: begin
                if (start_stop) state_d = ST_RUN;
            end
            ST_DONE: begin
                if (start_stop) begin
                    state_d = ST_IDLE;
                    min_d   = '0;
                    sec_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A stop seen during an update turns the return to RUN into PAUSE.
        if (state_q == ST_SEC_UPD || state_q == ST_MIN_UPD) begin
            if (state_d == ST_RUN && stop_req) begin
                state_d     = ST_PAUSE;
                stop_pend_d = 1'b0;
            end else if (state_d == ST_MIN_UPD) begin
                stop_pend_d = stop_req;
            end else begin
                stop_pend_d = 1'b0;
            end
        end

        // Nothing stays pending into a state that does not count.
        if (state_d == ST_PAUSE || state_d == ST_DONE || state_d == ST_IDLE) begin
            tick_pend_d = 1'b0;
            stop_pend_d = 1'b0;
        end

        if (clear) begin
            state_d     = ST_IDLE;
            min_d       = '0;
            sec_d       = '0;
            tick_pend_d = 1'b0;
            stop_pend_d = 1'b0;
        end

        case (state_d)
            ST_SEC_UPD: inc_a_d = mode_q ? ~{2'b00, sec_q} : {2'b00, sec_q};
            ST_MIN_UPD: inc_a_d = mode_q ? ~{1'b0, min_q} : {1'b0, min_q};
            default:    inc_a_d = '0;
        endcase

        running_d = (state_d == ST_RUN) || (state_d == ST_SEC_UPD) || (state_d == ST_MIN_UPD);
        busy_d    = (state_d == ST_SEC_UPD) || (state_d == ST_MIN_UPD);
        done_d    = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            min_q       <= '0;
            sec_q       <= '0;
            mode_q      <= 1'b0;
            tick_pend_q <= 1'b0;
            stop_pend_q <= 1'b0;
            inc_a_q     <= '0;
            running_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            mode_q      <= mode_d;
            tick_pend_q <= tick_pend_d;
            stop_pend_q <= stop_pend_d;
            inc_a_q     <= inc_a_d;
            running_q   <= running_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign inc_bus.inc_a = inc_a_q;
    assign min_o         = min_q;
    assign sec_o         = sec_q;
    assign running       = running_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_timer_step_ctrl.sv
// Bench for timer_step_ctrl: cycle vectors, directed corner sequences and a
// random event stream checked against a seconds-count model.
module tb_timer_step_ctrl;
    logic       clk;
    logic       rst_n;
    logic       tick, start_stop, clear, mode;
    logic [6:0] preset_min;
    logic [5:0] preset_sec;
    logic [6:0] min_o;
    logic [5:0] sec_o;
    logic       running, busy, done;

    int n_checks = 0;
    int n_pass   = 0;

    timer_step_ctrl_if bus ();
    assign bus.inc_y = bus.inc_a + 8'd1;

    timer_step_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .start_stop (start_stop),
        .clear      (clear),
        .mode       (mode),
        .preset_min (preset_min),
        .preset_sec (preset_sec),
        .inc_bus    (bus),
        .min_o      (min_o),
        .sec_o      (sec_o),
        .running    (running),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    endtask

    // One clock with the given pulses, sampled 1 time unit after the edge.
    task automatic cyc(input bit t, input bit ss, input bit cl);
        tick = t; start_stop = ss; clear = cl;
        @(posedge clk); #1;
        tick = 1'b0; start_stop = 1'b0; clear = 1'b0;
    endtask

    task automatic ticks(input int n, input int spacing);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            repeat (spacing - 1) cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic chk_cnt(input string name, input int m, input int s);
        chk({name, ".min"}, int'(min_o), m);
        chk({name, ".sec"}, int'(sec_o), s);
    endtask

    typedef struct {
        bit t, ss, cl, md;
        int pm, ps;
        int em, es;
        bit er, eb, ed;
        int ei;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    // Reference model: abstract run state plus total seconds.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    localparam int T_MAX = 99 * 60 + 59;
    int  m_st, m_t;
    bit  m_up;

    initial begin
        rst_n = 1'b0; tick = 0; start_stop = 0; clear = 0; mode = 0;
        preset_min = '0; preset_sec = '0;

        //          t ss cl md pm ps  em es er eb ed ei
        vecs[0]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 8'h00};
        vecs[1]  = '{0, 1, 0, 1, 1, 0,  1, 0, 1, 0, 0, 8'h00};
        vecs[2]  = '{1, 0, 0, 1, 1, 0,  1, 0, 1, 1, 0, 8'hFF};
        vecs[3]  = '{0, 0, 0, 1, 1, 0,  1,59, 1, 1, 0, 8'hFE};
        vecs[4]  = '{0, 0, 0, 1, 1, 0,  0,59, 1, 0, 0, 8'h00};
        vecs[5]  = '{1, 1, 0, 1, 1, 0,  0,59, 1, 1, 0, 8'hC4};
        vecs[6]  = '{0, 0, 0, 1, 1, 0,  0,58, 0, 0, 0, 8'h00};
        vecs[7]  = '{1, 0, 0, 1, 1, 0,  0,58, 0, 0, 0, 8'h00};
        vecs[8]  = '{0, 1, 0, 1, 1, 0,  0,58, 1, 0, 0, 8'h00};
        vecs[9]  = '{0, 0, 1, 1, 1, 0,  0, 0, 0, 0, 0, 8'h00};
        vecs[10] = '{0, 1, 0, 0, 1, 0,  0, 0, 1, 0, 0, 8'h00};
        vecs[11] = '{1, 0, 0, 0, 1, 0,  0, 0, 1, 1, 0, 8'h00};
        vecs[12] = '{0, 0, 0, 0, 1, 0,  0, 1, 1, 0, 0, 8'h00};
        vecs[13] = '{0, 1, 0, 1, 1, 0,  0, 1, 0, 0, 0, 8'h00};
        vecs[14] = '{0, 1, 0, 1, 1, 0,  0, 1, 1, 0, 0, 8'h00};
        vecs[15] = '{1, 0, 0, 1, 1, 0,  0, 1, 1, 1, 0, 8'h01};
        vecs[16] = '{1, 0, 0, 1, 1, 0,  0, 2, 1, 0, 0, 8'h00};
        vecs[17] = '{0, 0, 0, 1, 1, 0,  0, 2, 1, 1, 0, 8'h02};
        vecs[18] = '{0, 0, 0, 1, 1, 0,  0, 3, 1, 0, 0, 8'h00};
        vecs[19] = '{0, 0, 1, 1, 1, 0,  0, 0, 0, 0, 0, 8'h00};
        vecs[20] = '{0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 1, 8'h00};
        vecs[21] = '{1, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1, 8'h00};
        vecs[22] = '{0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 8'h00};
        vecs[23] = '{0, 1, 0, 1, 0, 1,  0, 1, 1, 0, 0, 8'h00};
        vecs[24] = '{1, 0, 0, 1, 0, 1,  0, 1, 1, 1, 0, 8'hFE};
        vecs[25] = '{0, 0, 0, 1, 0, 1,  0, 0, 0, 0, 1, 8'h00};
        vecs[26] = '{0, 0, 1, 1, 0, 1,  0, 0, 0, 0, 0, 8'h00};

        repeat (2) @(posedge clk);
        #1;
        chk("reset.inc_a", int'(bus.inc_a), 0);
        chk("reset.done", int'(done), 0);
        rst_n = 1'b1;

        // Cycle-exact vectors.
        for (int i = 0; i < NV; i++) begin
            mode       = vecs[i].md;
            preset_min = 7'(vecs[i].pm);
            preset_sec = 6'(vecs[i].ps);
            cyc(vecs[i].t, vecs[i].ss, vecs[i].cl);
            chk($sformatf("vec%0d.min", i), int'(min_o), vecs[i].em);
            chk($sformatf("vec%0d.sec", i), int'(sec_o), vecs[i].es);
            chk($sformatf("vec%0d.running", i), int'(running), int'(vecs[i].er));
            chk($sformatf("vec%0d.busy", i), int'(busy), int'(vecs[i].eb));
            chk($sformatf("vec%0d.done", i), int'(done), int'(vecs[i].ed));
            chk($sformatf("vec%0d.inc_a", i), int'(bus.inc_a), vecs[i].ei);
        end

        // Stopwatch with minute carry, then async reset mid-run at 03:17.
        mode = 1'b0;
        cyc(1'b0, 1'b1, 1'b0);
        ticks(59, 10);
        chk_cnt("sw59", 0, 59);
        cyc(1'b1, 1'b0, 1'b0);
        chk("carry.n.inc_a", int'(bus.inc_a), 8'h3B);
        chk("carry.n.busy", int'(busy), 1);
        chk_cnt("carry.n", 0, 59);
        cyc(1'b0, 1'b0, 1'b0);
        chk("carry.n1.inc_a", int'(bus.inc_a), 8'h00);
        chk("carry.n1.busy", int'(busy), 1);
        chk_cnt("carry.n1", 0, 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("carry.n2.busy", int'(busy), 0);
        chk_cnt("carry.n2", 1, 0);
        repeat (7) cyc(1'b0, 1'b0, 1'b0);
        ticks(1, 10);
        chk_cnt("sw0101", 1, 1);
        ticks(136, 4);
        chk_cnt("sw0317", 3, 17);
        #2 rst_n = 1'b0;
        #1;
        chk_cnt("arst", 0, 0);
        chk("arst.running", int'(running), 0);
        chk("arst.inc_a", int'(bus.inc_a), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1'b0, 1'b1, 1'b0);
        chk("restart.running", int'(running), 1);
        chk_cnt("restart", 0, 0);
        ticks(1, 4);
        chk_cnt("restart.tick", 0, 1);

        // Stopwatch overflow: stops and holds at 99:59.
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        ticks(T_MAX, 4);
        chk_cnt("sw9959", 99, 59);
        chk("sw9959.done", int'(done), 0);
        ticks(1, 4);
        chk_cnt("ovf", 99, 59);
        chk("ovf.done", int'(done), 1);
        chk("ovf.running", int'(running), 0);
        ticks(2, 4);
        chk_cnt("ovf.hold", 99, 59);
        cyc(1'b0, 1'b1, 1'b0);
        chk_cnt("ovf.exit", 0, 0);
        chk("ovf.exit.done", int'(done), 0);

        // Clear while in MIN_UPD.
        mode = 1'b1; preset_min = 7'd1; preset_sec = 6'd0;
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("minupd.busy", int'(busy), 1);
        cyc(1'b0, 1'b0, 1'b1);
        chk_cnt("minupd.clear", 0, 0);
        chk("minupd.clear.running", int'(running), 0);
        chk("minupd.clear.inc_a", int'(bus.inc_a), 0);

        // Random events against the seconds-count model.
        m_st = M_IDLE; m_t = 0; m_up = 1'b1;
        for (int k = 0; k < 400; k++) begin
            int  r;
            bit  et, es, ec;
            r          = int'($urandom_range(0, 99));
            mode       = 1'($urandom);
            preset_min = 7'($urandom_range(0, 2));
            preset_sec = 6'($urandom_range(0, 59));
            if ($urandom_range(0, 7) == 0) begin
                preset_min = '0; preset_sec = '0;
            end
            et = (r < 75);
            es = (r >= 75 && r < 95);
            ec = (r >= 95);
            if (ec) begin
                m_st = M_IDLE; m_t = 0;
            end else if (es) begin
                case (m_st)
                    M_IDLE: begin
                        m_up = !mode;
                        m_t  = m_up ? 0 : int'(preset_min) * 60 + int'(preset_sec);
                        m_st = (!m_up && m_t == 0) ? M_DONE : M_RUN;
                    end
                    M_RUN:   m_st = M_PAUSE;
                    M_PAUSE: m_st = M_RUN;
                    default: begin m_st = M_IDLE; m_t = 0; end
                endcase
            end else if (m_st == M_RUN) begin
                if (m_up) begin
                    if (m_t == T_MAX) m_st = M_DONE;
                    else m_t++;
                end else begin
                    m_t--;
                    if (m_t == 0) m_st = M_DONE;
                end
            end
            cyc(et, es, ec);
            repeat (3) cyc(1'b0, 1'b0, 1'b0);
            chk_cnt($sformatf("rnd%0d", k), m_t / 60, m_t % 60);
            chk($sformatf("rnd%0d.running", k), int'(running), int'(m_st == M_RUN));
            chk($sformatf("rnd%0d.done", k), int'(done), int'(m_st == M_DONE));
            chk($sformatf("rnd%0d.busy", k), int'(busy), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
